// File: rtl/bcd_converter.sv
// Sequential 16-bit binary to 4-digit packed BCD converter (double dabble, 16 shift cycles).
// Define BCD_CONVERTER_SATURATE_EN to clamp bcd_out to 16'h9999 when the operand exceeds 9999.
module bcd_converter (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] bin_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] bcd_out,
    output logic        overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [15:0] operand_r;
    logic [19:0] scratch_r;
    logic [3:0]  count_r;
    logic [15:0] adjusted_s;
    logic [15:0] load_value_s;
    logic        load_ovf_s;

    // Add 3 to every BCD digit that is 5 or more, ahead of the next left shift.
    function automatic logic [15:0] dabble_adjust(input logic [15:0] digits);
        logic [15:0] result;
        logic [3:0]  d;
        result = digits;
        for (int i = 0; i < 4; i++) begin
            d = digits[4*i +: 4];
            if (d >= 4'd5) begin
                result[4*i +: 4] = d + 4'd3;
            end else begin
                result[4*i +: 4] = d;
            end
        end
        return result;
    endfunction

    // The ten-thousands digit stays below 4 until the final shift, so it never needs adjusting.
    assign adjusted_s = dabble_adjust(scratch_r[15:0]);

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = SHIFT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                if (count_r == 4'd15) begin
                    state_next_s = LOAD;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            LOAD:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Result selection from the finished scratch register.
    always_comb begin
        load_ovf_s = (scratch_r[19:16] != 4'd0);
`ifdef BCD_CONVERTER_SATURATE_EN
        if (load_ovf_s) begin
            load_value_s = 16'h9999;
        end else begin
            load_value_s = scratch_r[15:0];
        end
`else
        load_value_s = scratch_r[15:0];
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            operand_r <= 16'h0000;
            scratch_r <= 20'h00000;
            count_r   <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            bcd_out   <= 16'h0000;
            overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        operand_r <= bin_in;
                        scratch_r <= 20'h00000;
                        count_r   <= 4'd0;
                        busy      <= 1'b1;
                    end
                end
                SHIFT: begin
                    {scratch_r, operand_r} <= {scratch_r[18:16], adjusted_s, operand_r, 1'b0};
                    count_r <= count_r + 4'd1;
                end
                LOAD: begin
                    bcd_out  <= load_value_s;
                    overflow <= load_ovf_s;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_converter.sv
// Scoreboard bench for bcd_converter: a driver pushes accepted operands, a monitor checks every cycle.
module tb_bcd_converter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] bin_in = 16'h0000;
    logic        busy;
    logic        done;
    logic [15:0] bcd_out;
    logic        overflow;

    bcd_converter dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] val;
        int          n;     // edge index at which the start was accepted
    } job_t;

    job_t        q[$];
    job_t        keep_q[$];
    int          cyc = 0;
    logic        rst_seen = 1'b0;
    int          next_free = 0;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] last_bcd = 16'h0000;
    logic        last_ovf = 1'b0;
    logic        exp_busy;
    logic        exp_done;

    // Decimal reference: digits of the operand obtained with plain division.
    function automatic logic [15:0] model_bcd(input int v);
        int m;
`ifdef BCD_CONVERTER_SATURATE_EN
        if (v >= 10000) return 16'h9999;
`endif
        m = v % 10000;
        return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    // Drive one cycle of inputs and record whether the converter will accept the start.
    task automatic drive(input logic r, input logic s, input logic [15:0] b);
        job_t j;
        @(posedge clk);
        #1;
        rst    = r;
        start  = s;
        bin_in = b;
        if (r) begin
            next_free = cyc + 1;
        end else if (s && cyc >= next_free) begin
            j.val = b;
            j.n   = cyc + 1;
            q.push_back(j);
            next_free = cyc + 18;
        end
    endtask

    // Monitor: compare every output each cycle against the scoreboard.
    always @(negedge clk) begin
        if (cyc > 0) begin
            if (rst_seen) begin
                keep_q.delete();
                foreach (q[i]) if (q[i].n > cyc) keep_q.push_back(q[i]);
                q = keep_q;
                last_bcd = 16'h0000;
                last_ovf = 1'b0;
            end
            exp_busy = (q.size() > 0) && (cyc >= q[0].n) && (cyc <= q[0].n + 16);
            exp_done = (q.size() > 0) && (cyc == q[0].n + 17);
            check1("busy", busy, exp_busy);
            check1("done", done, exp_done);
            if (exp_done) begin
                last_bcd = model_bcd(int'(q[0].val));
                last_ovf = (int'(q[0].val) >= 10000);
                void'(q.pop_front());
            end
            check16("bcd_out", bcd_out, last_bcd);
            check1("overflow", overflow, last_ovf);
        end
    end

    initial begin
        logic [15:0] directed [9];
        logic [15:0] b;
        directed = '{16'h04D2, 16'h270F, 16'h0000, 16'hFFFF, 16'h2710,
                     16'd1, 16'd9, 16'd10, 16'd9998};
        repeat (3) drive(1'b1, 1'b0, 16'h0000);

        // Directed operands, start held high throughout so the next lands in the done cycle.
        foreach (directed[i]) begin
            drive(1'b0, 1'b1, directed[i]);
            repeat (17) drive(1'b0, 1'b1, 16'($urandom));
        end

        // Random traffic with occasional resets.
        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(0, 3))
                0:       b = 16'($urandom_range(0, 9999));
                1:       b = 16'($urandom_range(9990, 10010));
                2:       b = 16'($urandom);
                default: b = 16'(65535 - $urandom_range(0, 5));
            endcase
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0), b);
        end

        // Reset five cycles into a conversion, then convert again right after reset.
        repeat (20) drive(1'b0, 1'b0, 16'h0000);
        drive(1'b0, 1'b1, 16'd4321);
        repeat (4) drive(1'b0, 1'b0, 16'($urandom));
        drive(1'b1, 1'b1, 16'd1111);
        drive(1'b0, 1'b1, 16'd8765);
        repeat (17) drive(1'b0, 1'b0, 16'($urandom));

        repeat (25) drive(1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d conversions never completed, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
